// File: rtl/dmem_ctrl_pkg.sv
// Shared constants and types for the data-memory controller and its lane logic.
// Access-type encodings, default depth and the request legality check.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'd0,
    MEM_HALF = 2'd1,
    MEM_BYTE = 2'd2,
    MEM_RSVD = 2'd3
  } mem_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 2048;

  // Misaligned, out-of-range or reserved-type requests are rejected without touching memory.
  function automatic logic access_err(mem_type_e t, logic [31:0] a, int unsigned depth);
    logic bad;
    bad = 1'b0;
    if (t == MEM_RSVD)                    bad = 1'b1;
    if (t == MEM_WORD && a[1:0] != 2'b00) bad = 1'b1;
    if (t == MEM_HALF && a[0])            bad = 1'b1;
    if ({2'b00, a[31:2]} >= depth)        bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between a core's load-store stage and dmem_ctrl.
// The original port names are kept so existing connections map one-to-one.
interface dmem_ctrl_if;
  logic        Req;
  logic        We;
  logic [1:0]  StoreType;
  logic [1:0]  LoadType;
  logic        SignRead;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] WPC;
  logic        Ready;
  logic        Done;
  logic [31:0] RD;
  logic        AddrErr;

  modport master (
    output Req, We, StoreType, LoadType, SignRead, Addr, WD, WPC,
    input  Ready, Done, RD, AddrErr
  );

  modport slave (
    input  Req, We, StoreType, LoadType, SignRead, Addr, WD, WPC,
    output Ready, Done, RD, AddrErr
  );
endinterface

// File: rtl/dmem_ctrl_lane.sv
// dmem_lane: purely combinational byte-lane logic for the data memory --
// store byte enables and merge, load lane selection and extension.
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  mem_type_e   store_type,
  input  mem_type_e   load_type,
  input  logic        sign_read,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] old_word,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [31:0] wd_rep;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    be     = '0;
    wd_rep = '0;
    case (store_type)
      MEM_WORD: begin
        be     = 4'b1111;
        wd_rep = wd;
      end
      MEM_HALF: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wd[15:0]}};
      end
      MEM_BYTE: begin
        be     = 4'b0001 << addr_lo;
        wd_rep = {4{wd[7:0]}};
      end
      default: ;
    endcase

    // Store data is replicated across lanes so each enabled lane takes its own slice.
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  always_comb begin
    half_sel  = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    byte_sel  = old_word[{addr_lo, 3'b000} +: 8];
    load_data = '0;
    case (load_type)
      MEM_WORD: load_data = old_word;
      MEM_HALF: load_data = {{16{sign_read & half_sel[15]}}, half_sel};
      MEM_BYTE: load_data = {{24{sign_read & byte_sel[7]}}, byte_sel};
      default:  load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Fixed-latency data-memory controller: accepts one request while idle,
// completes it LATENCY cycles later with a one-cycle Done pulse.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned LOG_EN      = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  dmem_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e      state, state_nx;
  logic [2:0]  cnt;

  logic        we_q;
  mem_type_e   st_q, ld_q;
  logic        sign_q;
  logic [31:0] addr_q, wd_q, wpc_q;

  logic        done_q, err_q;
  logic [31:0] rd_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             err;
  logic [3:0]       be;
  logic [31:0]      merged, load_data;

  assign idx = addr_q[IDX_W+1:2];
  assign err = access_err(we_q ? st_q : ld_q, addr_q, DEPTH_WORDS);

  dmem_lane u_lane (
    .store_type (st_q),
    .load_type  (ld_q),
    .sign_read  (sign_q),
    .addr_lo    (addr_q[1:0]),
    .wd         (wd_q),
    .old_word   (mem[idx]),
    .be         (be),
    .merged     (merged),
    .load_data  (load_data)
  );

  assign bus.Ready   = (state == ST_IDLE);
  assign bus.Done    = done_q;
  assign bus.RD      = rd_q;
  assign bus.AddrErr = err_q;

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.Req)     state_nx = ST_BUSY;
      ST_BUSY: if (cnt == 3'd0) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt    <= '0;
      done_q <= 1'b0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Req) begin
            we_q   <= bus.We;
            st_q   <= mem_type_e'(bus.StoreType);
            ld_q   <= mem_type_e'(bus.LoadType);
            sign_q <= bus.SignRead;
            addr_q <= bus.Addr;
            wd_q   <= bus.WD;
            wpc_q  <= bus.WPC;
            cnt    <= 3'(LATENCY - 1);
          end
        end
        ST_BUSY: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            done_q <= 1'b1;
            err_q  <= err;
            rd_q   <= '0;
            if (!err) begin
              if (we_q) begin
                if (be != 4'b0000) mem[idx] <= merged;
                if (LOG_EN != 0)
                  $display("~%h: *%h <= %h", wpc_q, {addr_q[31:2], 2'b00}, merged);
              end else begin
                rd_q <= load_data;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed corner cases plus random traffic
// compared against a byte-addressed reference model.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int unsigned DW = 64;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  dmem_ctrl_if bus_a();
  dmem_ctrl_if bus_b();

  dmem_ctrl #(.DEPTH_WORDS(DW), .LATENCY(2), .LOG_EN(1)) u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  dmem_ctrl #(.DEPTH_WORDS(DW), .LATENCY(1), .LOG_EN(0)) u_dut_l1 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [DW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(logic [1:0] t);
    case (t)
      2'd0:    return 4;
      2'd1:    return 2;
      2'd2:    return 1;
      default: return 0;
    endcase
  endfunction

  // Reference: memory as bytes, little-endian within a word; accesses are sz consecutive bytes.
  task automatic model_access(input logic we, input logic [1:0] st, input logic [1:0] lt,
                              input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    int unsigned sz;
    logic [31:0] ba;
    sz  = size_of(we ? st : lt);
    err = (sz == 0) || (a % sz != 0) || ((a / 4) >= DW);
    rd  = '0;
    if (err) return;
    for (int unsigned b = 0; b < sz; b++) begin
      ba = a + b;
      if (we) mdl[ba / 4][8*(ba % 4) +: 8] = wd[8*b +: 8];
      else    rd[8*b +: 8] = mdl[ba / 4][8*(ba % 4) +: 8];
    end
    if (!we && sgn && sz < 4 && rd[8*sz-1])
      for (int unsigned b = sz; b < 4; b++) rd[8*b +: 8] = 8'hFF;
  endtask

  // Entered and left on a falling edge; the exit edge is the Done cycle.
  task automatic access_a(input logic we, input logic [1:0] st, input logic [1:0] lt,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          input string tag);
    logic [31:0] erd;
    logic        eerr;
    int          n;
    n = 0;
    while (!bus_a.Ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check_eq({tag, "_ready"}, 32'(bus_a.Ready), 32'd1);
    bus_a.We        = we;
    bus_a.StoreType = st;
    bus_a.LoadType  = lt;
    bus_a.SignRead  = sgn;
    bus_a.Addr      = a;
    bus_a.WD        = wd;
    bus_a.WPC       = $urandom;
    bus_a.Req       = 1'b1;
    @(posedge Clock);
    #1 bus_a.Req = 1'b0;
    model_access(we, st, lt, sgn, a, wd, erd, eerr);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!bus_a.Done && n < 10);
    check_eq({tag, "_lat"}, n, 32'd3);
    check_eq({tag, "_rd"},  bus_a.RD, erd);
    check_eq({tag, "_err"}, 32'(bus_a.AddrErr), 32'(eerr));
  endtask

  initial begin
    logic [1:0]  st, lt;
    logic [31:0] a;
    int unsigned sz;

    foreach (mdl[i]) mdl[i] = '0;
    {bus_a.Req, bus_a.We, bus_a.StoreType, bus_a.LoadType, bus_a.SignRead} = '0;
    {bus_a.Addr, bus_a.WD, bus_a.WPC} = '0;
    {bus_b.Req, bus_b.We, bus_b.StoreType, bus_b.LoadType, bus_b.SignRead} = '0;
    {bus_b.Addr, bus_b.WD, bus_b.WPC} = '0;

    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check_eq("rst_ready",   32'(bus_a.Ready),   32'd1);
    check_eq("rst_done",    32'(bus_a.Done),    32'd0);
    check_eq("rst_rd",      bus_a.RD,           32'd0);
    check_eq("rst_addrerr", 32'(bus_a.AddrErr), 32'd0);
    check_eq("rst_done_l1", 32'(bus_b.Done),    32'd0);

    // LATENCY=1 with Req held high: one acceptance every second cycle.
    bus_b.Req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      check_eq("tp_done",  32'(bus_b.Done),  32'(i % 2 == 1));
      check_eq("tp_ready", 32'(bus_b.Ready), 32'(i % 2 == 1));
      if (bus_b.Done) check_eq("tp_rd", bus_b.RD, 32'd0);
    end
    bus_b.Req = 1'b0;

    access_a(1'b1, 2'd0, 2'd0, 1'b0, 32'h10, 32'h12345678, "st_w10");
    access_a(1'b0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h0, "ld_w10");
    check_eq("ld_w10_const", bus_a.RD, 32'h12345678);
    access_a(1'b1, 2'd2, 2'd0, 1'b0, 32'h13, 32'h000000AB, "st_b13");
    access_a(1'b0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h0, "ld_w10_after_b");
    check_eq("merge_const", bus_a.RD, 32'h12345678 & 32'h00FFFFFF | 32'hAB000000);
    access_a(1'b0, 2'd0, 2'd2, 1'b1, 32'h13, 32'h0, "ld_b13_s");
    check_eq("ld_b13_s_const", bus_a.RD, 32'hFFFFFFAB);
    access_a(1'b0, 2'd0, 2'd2, 1'b0, 32'h13, 32'h0, "ld_b13_u");
    check_eq("ld_b13_u_const", bus_a.RD, 32'h000000AB);
    access_a(1'b0, 2'd0, 2'd1, 1'b0, 32'h21, 32'h0, "ld_h21");
    check_eq("ld_h21_err", 32'(bus_a.AddrErr), 32'd1);
    access_a(1'b1, 2'd0, 2'd0, 1'b0, 32'h00, 32'hCAFEF00D, "st_w0");
    access_a(1'b1, 2'd0, 2'd0, 1'b0, DW * 4, 32'hDEADBEEF, "st_oor");
    check_eq("st_oor_err", 32'(bus_a.AddrErr), 32'd1);
    access_a(1'b0, 2'd0, 2'd0, 1'b0, 32'h00, 32'h0, "ld_w0_unchanged");
    check_eq("oor_nowrite", bus_a.RD, 32'hCAFEF00D);
    access_a(1'b1, 2'd3, 2'd0, 1'b0, 32'h04, 32'h11111111, "st_rsvd");
    access_a(1'b0, 2'd0, 2'd3, 1'b0, 32'h04, 32'h0, "ld_rsvd");

    for (int k = 0; k < 200; k++) begin
      st = 2'($urandom_range(0, 3));
      lt = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, DW * 4 + 15);
      sz = size_of($urandom_range(0, 1) != 0 ? st : lt);
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      access_a(1'($urandom_range(0, 1)), st, lt, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end

    // Reset while a store is in flight: no completion, memory cleared, Req during reset ignored.
    bus_a.We = 1'b1; bus_a.StoreType = 2'd0; bus_a.Addr = 32'h40; bus_a.WD = 32'h5A5A5A5A;
    bus_a.Req = 1'b1;
    @(posedge Clock);
    #1 bus_a.Req = 1'b0;
    @(negedge Clock);
    Reset     = 1'b1;
    bus_a.Req = 1'b1;
    @(negedge Clock);
    Reset     = 1'b0;
    bus_a.Req = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rstbusy_nodone", 32'(bus_a.Done),  32'd0);
      check_eq("rstbusy_ready",  32'(bus_a.Ready), 32'd1);
      @(negedge Clock);
    end
    access_a(1'b0, 2'd0, 2'd0, 1'b0, 32'h40, 32'h0, "ld_w40_after_rst");
    check_eq("ld_w40_const", bus_a.RD, 32'h0);
    access_a(1'b0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h0, "ld_w10_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 2048, memory depth in 32-bit words (power of two, >=4).
REQ-002 Parameter LATENCY, default 2, access latency in cycles from request acceptance to completion (legal 1..8).
REQ-003 Parameter LOG_EN, default 1, enables the per-store simulation log line.
REQ-004 Clock  in  1  clock; all state updates on rising edge.
REQ-005 Reset  in  1  reset, synchronous, active-high.
REQ-006 Req  in  1  access request; sampled only while Ready=1.
REQ-007 We  in  1  1=store, 0=load.
REQ-008 StoreType  in  2  0=word, 1=halfword, 2=byte, 3=reserved.
REQ-009 LoadType  in  2  0=word, 1=halfword, 2=byte, 3=reserved.
REQ-010 SignRead  in  1  1=sign-extend halfword/byte loads, 0=zero-extend.
REQ-011 Addr  in  32  byte address.
REQ-012 WD  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-013 WPC  in  32  PC of the issuing instruction, used only for the log line.
REQ-014 Ready  out  1  controller idle, request may be accepted this cycle.
REQ-015 Done  out  1  one-cycle completion pulse.
REQ-016 RD  out  32  registered, extended load data; valid while Done=1.
REQ-017 AddrErr  out  1  valid with Done; 1 = request rejected (misaligned, out of range or reserved type).

Function
REQ-018 FSM states IDLE and BUSY; Ready = (state==IDLE).
REQ-019 IDLE with Req=1 at an edge: latch We, type, SignRead, Addr, WD and WPC; load counter with LATENCY-1; go to BUSY.
REQ-020 BUSY with counter!=0: decrement counter; Req ignored.
REQ-021 BUSY with counter==0 at an edge: perform access; Done<=1; go to IDLE.
REQ-022 Done is 0 in every other cycle; a request accepted at edge k produces Done=1 in the cycle after edge k+LATENCY.
REQ-023 A new request may be accepted in the Done cycle (back-to-back); sustained throughput is one access per LATENCY+1 cycles.
REQ-024 Error check: word with Addr[1:0]!=0, halfword with Addr[0]=1, Addr[31:2]>=DEPTH_WORDS, or type==3.
REQ-025 On error: no memory write; RD<=0; AddrErr<=1 with Done.
REQ-026 Store byte enables: word 1111; halfword 0011 when Addr[1]=0, 1100 when Addr[1]=1; byte 0001/0010/0100/1000 for Addr[1:0]=0/1/2/3.
REQ-027 Store writes only enabled lanes of word Addr[31:2] with the corresponding low bits of WD; other lanes keep their value.
REQ-028 Load selects the halfword by Addr[1] or the byte by Addr[1:0], then extends to 32 bits per SignRead; word loads return the full word.
REQ-029 Valid load: RD<=extended data and AddrErr<=0. Valid store: RD<=0 and AddrErr<=0.
REQ-030 With LOG_EN=1, each successful store prints "~<WPC>: *<Addr[31:2],00> <= <merged word>" in hex.

Reset
REQ-031 Reset=1 at an edge: state<=IDLE, counter<=0, Done<=0, RD<=0, AddrErr<=0, and every memory word cleared to 0.
REQ-032 Reset takes priority over every other event; a request in flight is aborted with no write and no Done pulse.
REQ-033 A Req asserted in the reset cycle is not accepted.

Structure
REQ-034 Type encodings (word/half/byte/reserved) and the default DEPTH_WORDS are shared constants in the common header, also used by the decode stage.
REQ-035 Lane logic is one combinational sub-module, dmem_lane: byte-enable generation, store merge and load extraction/extension; the FSM, counter and array stay in dmem_ctrl.

Verification
REQ-036 LATENCY=2: store word 0x12345678 to 0x10, then load word 0x10 -> each Done 3 cycles after acceptance; RD=0x12345678, AddrErr=0.
REQ-037 Store byte 0xAB to 0x13 over word 0 -> word 0xAB000000. Then load byte 0x13 with SignRead=1 -> RD=0xFFFFFFAB; with SignRead=0 -> 0x000000AB.
REQ-038 Load halfword from 0x21 -> AddrErr=1 with Done, RD=0. Store word to DEPTH_WORDS*4 -> AddrErr=1, memory unchanged.
REQ-039 Req held high continuously with LATENCY=1 -> accepted every 2nd cycle; Req during BUSY has no effect.
REQ-040 Reset asserted in BUSY of a store to 0x40 -> no Done; a subsequent load of 0x40 returns 0.
